csr_mmio_rr_arbiter: RTL and testbench
======================================

// Module: csr_mmio_rr_arbiter
// PURPOSE
//  Shares one MMIO/CSR master port (FME and PCIe CSR space, e.g. FME_SCRATCHPAD0 0x28,
//  PCIE_SCRATCHPAD 0x10008, PCIE_TESTPAD 0x10028) between NUM_REQ requesters.
//  Round-robin grant, one transaction outstanding downstream, response routed back to owner.
//  Sits between test/management agents and the CSR decode fabric.
// PARAMETERS
//  NUM_REQ        2     number of requesters (2..8)
//  ADDR_W         32    CSR byte address width
//  DATA_W         64    CSR data width
//  TIMEOUT_CYCLES 1024  WAIT_RSP cycle limit (used only with CSR_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               synchronous reset, active-low
//  req_valid    in   NUM_REQ         per-requester request valid
//  req_ready    out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_write    in   NUM_REQ         1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W  packed write data
//  rsp_valid    out  NUM_REQ         one-hot 1-cycle response strobe to owner
//  rsp_rdata    out  DATA_W          read data (write: 0), shared by all requesters
//  rsp_err      out  1               error flag qualifying rsp_valid
//  m_req_valid  out  1               downstream request valid
//  m_req_ready  in   1               downstream accept
//  m_req_write  out  1               downstream write flag
//  m_req_addr   out  ADDR_W          downstream address
//  m_req_wdata  out  DATA_W          downstream write data
//  m_rsp_valid  in   1               downstream response (reads and write acks)
//  m_rsp_rdata  in   DATA_W          downstream read data
//  busy         out  1               FSM not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, FSM=IDLE, rr pointer=0, owner=0.
//  FSM: IDLE -> ISSUE -> WAIT_RSP -> RESP -> IDLE.
//  IDLE: req_ready = combinational one-hot grant; first valid at or above pointer, searched
//   upward mod NUM_REQ. On valid&ready: latch write/addr/wdata/owner, pointer=owner+1 mod
//   NUM_REQ, go ISSUE. No valid: stay, req_ready=0.
//  ISSUE: m_req_valid=1 with latched fields held stable until m_req_ready=1 -> WAIT_RSP.
//   req_ready=0 in every state except IDLE.
//  WAIT_RSP: on m_rsp_valid latch rdata (0 for writes), rsp_err=0 -> RESP.
//  RESP: rsp_valid[owner]=1 for exactly one cycle with rsp_rdata/rsp_err -> IDLE.
//  Min latency: accept at T, m_req_valid at T+1, m_rsp_valid at T+2 -> rsp_valid at T+3.
//   Back-to-back grants every 4 cycles minimum.
//  m_rsp_valid outside WAIT_RSP (stray or post-reset) is ignored.
//  Requester dropping valid before ready: permitted, no grant. Same cycle valid and
//   m_rsp_valid: no effect on grant (grant only in IDLE).
//  Reset mid-transaction: return to IDLE immediately; no response to owner.
// CONFIGURATION
//  CSR_ARB_TIMEOUT_EN defined: 16-bit counter clears on WAIT_RSP entry. At TIMEOUT_CYCLES
//   with no m_rsp_valid -> RESP with rsp_err=1, rsp_rdata all-ones. A late response
//   arriving after that is dropped.
//  Not defined: WAIT_RSP waits indefinitely. rsp_err is tied 0. No counter logic.
// TESTING
//  1 req0 write 0x10008 = 64'hDEAD_BEEF_0123_4567, then read 0x10008 -> rsp_valid=2'b01,
//    rsp_rdata=64'hDEAD_BEEF_0123_4567, rsp_err=0.
//  2 req0 and req1 hold valid continuously (reads 0x28 / 0x10028) -> grants alternate
//    0,1,0,1; rsp_valid one-hot matches grant order; no starvation over 8 txns.
//  3 m_req_ready low 5 cycles in ISSUE -> m_req_valid/addr/wdata stable for all 6 cycles;
//    req_ready=0 throughout.
//  4 stray m_rsp_valid pulse in IDLE -> no rsp_valid, FSM stays IDLE.
//  5 rst_n=0 during WAIT_RSP, then m_rsp_valid arrives -> no rsp_valid; busy=0; next
//    grant goes to req0.
//  6 [CSR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16] read with no downstream response ->
//    rsp_valid 16 cycles after WAIT_RSP entry, rsp_err=1, rsp_rdata=all-ones.

Source files
------------

// File: rtl/csr_mmio_rr_arbiter.sv
// ----------------------------------------------------------------------------
// csr_mmio_rr_arbiter
// Shares one MMIO/CSR master port between NUM_REQ requesters. The arbiter
// grants round-robin, keeps one transaction outstanding downstream, and routes
// each response back to the requester that owns it.
//
// Optional feature macro: CSR_ARB_TIMEOUT_EN
//   When it is defined, a WAIT_RSP watchdog of TIMEOUT_CYCLES cycles is built.
//   On expiry the arbiter completes the transaction with rsp_err=1 and
//   all-ones read data. Any late response that arrives afterwards is dropped.
//   When it is undefined, WAIT_RSP waits indefinitely and rsp_err is tied 0.
// ----------------------------------------------------------------------------
module csr_mmio_rr_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      m_req_valid,
   input  logic                      m_req_ready,
   output logic                      m_req_write,
   output logic [ADDR_W-1:0]         m_req_addr,
   output logic [DATA_W-1:0]         m_req_wdata,
   input  logic                      m_rsp_valid,
   input  logic [DATA_W-1:0]         m_rsp_rdata,
   output logic                      busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;
   localparam logic [1:0] ST_RESP     = 2'd3;

   logic [1:0]         state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] grant;
   logic               grant_found;
   logic               accept;
   logic               lat_write;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;
   logic [DATA_W-1:0]  rdata_q;

`ifdef CSR_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt;
   logic        err_q;
`endif

   // Round-robin search: first valid requester at or above the pointer, wrapping
   always_comb begin
      int               sum;
      logic [PTR_W-1:0] idx;
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      sum         = 0;
      idx         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         idx = PTR_W'(sum);
         if (!grant_found && req_valid[idx]) begin
            grant[idx]  = 1'b1;
            grant_idx   = idx;
            grant_found = 1'b1;
         end
      end
   end

   // Pointer moves to the requester just after the one that was granted
   always_comb begin
      next_ptr = '0;
      if (grant_idx != PTR_W'(NUM_REQ - 1)) begin
         next_ptr = grant_idx + 1'b1;
      end
   end

   // Grants are offered only in IDLE and never while reset is asserted
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      if (rst_n && (state == ST_IDLE)) begin
         req_ready = grant;
         accept    = grant_found;
      end
   end

   // One-cycle response strobe aimed at the owner of the finished transaction
   always_comb begin
      rsp_valid = '0;
      if (state == ST_RESP) begin
         rsp_valid[owner] = 1'b1;
      end
   end

   assign m_req_valid = (state == ST_ISSUE);
   assign m_req_write = lat_write;
   assign m_req_addr  = lat_addr;
   assign m_req_wdata = lat_wdata;
   assign rsp_rdata   = rdata_q;
   assign busy        = (state != ST_IDLE);

`ifdef CSR_ARB_TIMEOUT_EN
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Transaction FSM: latch the granted request, issue it, await the response, report it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
`ifdef CSR_ARB_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_write <= req_write[grant_idx];
                  lat_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                  lat_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                  owner     <= grant_idx;
                  rr_ptr    <= next_ptr;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_req_ready) begin
                  state   <= ST_WAIT_RSP;
`ifdef CSR_ARB_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            ST_WAIT_RSP: begin
               if (m_rsp_valid) begin
                  rdata_q <= lat_write ? '0 : m_rsp_rdata;
                  state   <= ST_RESP;
`ifdef CSR_ARB_TIMEOUT_EN
                  err_q   <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  rdata_q <= '1;
                  err_q   <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
`endif
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_mmio_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_csr_mmio_rr_arbiter
// Directed bench for csr_mmio_rr_arbiter with two requesters. Inputs change
// on the falling edge and outputs are sampled 1 ns later. With
// CSR_ARB_TIMEOUT_EN defined, the bench also exercises the response watchdog,
// configured for 16 cycles.
// ----------------------------------------------------------------------------
module tb_csr_mmio_rr_arbiter;

   logic         clk;
   logic         rst_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [1:0]   req_write;
   logic [63:0]  req_addr;
   logic [127:0] req_wdata;
   logic [1:0]   rsp_valid;
   logic [63:0]  rsp_rdata;
   logic         rsp_err;
   logic         m_req_valid;
   logic         m_req_ready;
   logic         m_req_write;
   logic [31:0]  m_req_addr;
   logic [63:0]  m_req_wdata;
   logic         m_rsp_valid;
   logic [63:0]  m_rsp_rdata;
   logic         busy;

   int pass_count  = 0;
   int check_count = 0;

   csr_mmio_rr_arbiter #(
      .NUM_REQ        (2),
      .ADDR_W         (32),
      .DATA_W         (64),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .m_req_valid (m_req_valid),
      .m_req_ready (m_req_ready),
      .m_req_write (m_req_write),
      .m_req_addr  (m_req_addr),
      .m_req_wdata (m_req_wdata),
      .m_rsp_valid (m_rsp_valid),
      .m_rsp_rdata (m_rsp_rdata),
      .busy        (busy)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the per-cycle handshake inputs on the falling edge, then let them settle
   task automatic applyStimulus(input logic [1:0] valid, input logic mready, input logic mrsp);
      @(negedge clk);
      req_valid   = valid;
      m_req_ready = mready;
      m_rsp_valid = mrsp;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Four-cycle transaction with the fastest downstream: accept, issue, respond, report
   task automatic runTransaction(input string tag, input logic [1:0] valid, input logic [1:0] exp_grant,
                                 input logic exp_write, input logic [31:0] exp_addr,
                                 input logic [63:0] exp_wdata, input logic [63:0] rsp_data,
                                 input logic [63:0] exp_rdata);
      applyStimulus(valid, 1'b1, 1'b0);
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'(exp_grant));
      checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
      applyStimulus(valid, 1'b1, 1'b0);
      checkOutput({tag, "_mvalid"}, 64'(m_req_valid), 64'd1);
      checkOutput({tag, "_mwrite"}, 64'(m_req_write), 64'(exp_write));
      checkOutput({tag, "_maddr"}, 64'(m_req_addr), 64'(exp_addr));
      checkOutput({tag, "_mwdata"}, m_req_wdata, exp_wdata);
      checkOutput({tag, "_issue_ready"}, 64'(req_ready), 64'd0);
      m_rsp_rdata = rsp_data;
      applyStimulus(valid, 1'b0, 1'b1);
      checkOutput({tag, "_wait_mvalid"}, 64'(m_req_valid), 64'd0);
      checkOutput({tag, "_wait_rspv"}, 64'(rsp_valid), 64'd0);
      applyStimulus(valid, 1'b0, 1'b0);
      checkOutput({tag, "_rspv"}, 64'(rsp_valid), 64'(exp_grant));
      checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
      checkOutput({tag, "_err"}, 64'(rsp_err), 64'd0);
   endtask

   // Directed test sequence
   initial begin
      logic [1:0]  g;
      logic [31:0] a;
      logic [63:0] w;

      rst_n       = 1'b0;
      req_valid   = 2'b00;
      req_write   = 2'b00;
      req_addr    = '0;
      req_wdata   = '0;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = '0;

      // Reset: no grant while reset is held, and every output is cleared afterwards
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("rst_ready_gated", 64'(req_ready), 64'd0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_rspv", 64'(rsp_valid), 64'd0);
      checkOutput("rst_mvalid", 64'(m_req_valid), 64'd0);
      checkOutput("rst_maddr", 64'(m_req_addr), 64'd0);
      checkOutput("rst_rdata", rsp_rdata, 64'd0);
      checkOutput("rst_err", 64'(rsp_err), 64'd0);
      rst_n = 1'b1;

      // Requester 0 writes PCIE_SCRATCHPAD, then reads it back
      req_write            = 2'b01;
      req_addr[31:0]       = 32'h0001_0008;
      req_wdata[63:0]      = 64'hDEAD_BEEF_0123_4567;
      runTransaction("wr0", 2'b01, 2'b01, 1'b1, 32'h0001_0008, 64'hDEAD_BEEF_0123_4567,
                     64'h5555_5555_5555_5555, 64'd0);
      req_write = 2'b00;
      runTransaction("rd0", 2'b01, 2'b01, 1'b0, 32'h0001_0008, 64'hDEAD_BEEF_0123_4567,
                     64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);

      // Downstream stalls for 5 cycles: issued fields stay stable and no new grant appears
      req_addr[63:32]   = 32'h0001_0028;
      req_wdata[127:64] = 64'hA5A5_A5A5_5A5A_5A5A;
      applyStimulus(2'b10, 1'b0, 1'b0);
      checkOutput("stall_grant", 64'(req_ready), 64'b10);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'b10, (i == 5) ? 1'b1 : 1'b0, 1'b0);
         checkOutput("stall_mvalid", 64'(m_req_valid), 64'd1);
         checkOutput("stall_maddr", 64'(m_req_addr), 64'h0001_0028);
         checkOutput("stall_mwdata", m_req_wdata, 64'hA5A5_A5A5_5A5A_5A5A);
         checkOutput("stall_ready", 64'(req_ready), 64'd0);
      end
      m_rsp_rdata = 64'h77;
      applyStimulus(2'b00, 1'b0, 1'b1);
      checkOutput("stall_wait_busy", 64'(busy), 64'd1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("stall_rspv", 64'(rsp_valid), 64'b10);
      checkOutput("stall_rdata", rsp_rdata, 64'h77);

      // A stray downstream response in IDLE is ignored
      m_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      applyStimulus(2'b00, 1'b0, 1'b1);
      checkOutput("stray_busy", 64'(busy), 64'd0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("stray_rspv", 64'(rsp_valid), 64'd0);
      checkOutput("stray_busy2", 64'(busy), 64'd0);

      // Reset during WAIT_RSP: the later response produces nothing, and the pointer restarts at 0
      req_addr[31:0] = 32'h0000_0028;
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("midrst_grant", 64'(req_ready), 64'b01);
      applyStimulus(2'b00, 1'b1, 1'b0);
      checkOutput("midrst_mvalid", 64'(m_req_valid), 64'd1);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("midrst_wait_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      m_rsp_rdata = 64'h1234;
      applyStimulus(2'b00, 1'b0, 1'b1);
      checkOutput("midrst_late_rspv", 64'(rsp_valid), 64'd0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("midrst_after_rspv", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_after_busy", 64'(busy), 64'd0);

      // Both requesters hold valid: grants alternate 0,1,0,1 over eight transactions
      req_addr[31:0]    = 32'h0000_0028;
      req_addr[63:32]   = 32'h0001_0028;
      req_wdata[63:0]   = 64'h0000_0000_0000_00A0;
      req_wdata[127:64] = 64'h0000_0000_0000_00B1;
      for (int i = 0; i < 8; i++) begin
         g = (i % 2 == 0) ? 2'b01 : 2'b10;
         a = (i % 2 == 0) ? 32'h0000_0028 : 32'h0001_0028;
         w = (i % 2 == 0) ? 64'hA0 : 64'hB1;
         runTransaction("rr", 2'b11, g, 1'b0, a, w, 64'hC000 + 64'(i), 64'hC000 + 64'(i));
      end

`ifdef CSR_ARB_TIMEOUT_EN
      // With no downstream response, the watchdog reports an error 16 cycles after WAIT_RSP entry
      applyStimulus(2'b01, 1'b1, 1'b0);
      checkOutput("tmo_grant", 64'(req_ready), 64'b01);
      applyStimulus(2'b00, 1'b1, 1'b0);
      checkOutput("tmo_mvalid", 64'(m_req_valid), 64'd1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'b00, 1'b0, 1'b0);
         checkOutput("tmo_waiting_rspv", 64'(rsp_valid), 64'd0);
      end
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("tmo_rspv", 64'(rsp_valid), 64'b01);
      checkOutput("tmo_err", 64'(rsp_err), 64'd1);
      checkOutput("tmo_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(2'b00, 1'b0, 1'b1);
      checkOutput("tmo_late_busy", 64'(busy), 64'd0);
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("tmo_late_rspv", 64'(rsp_valid), 64'd0);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
